// File: rtl/ycbcr_stream_out.sv
// Raster-order RGB plane reader with BT.601 full-range YCbCr conversion onto a valid/ready stream.
// Optional build macro YCBCR_GRAY_EN adds a per-frame `gray` input that forces cb=cr=128.
module ycbcr_stream_out #(
    parameter int PIX = 16384,
    parameter int AW  = 14
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
`ifdef YCBCR_GRAY_EN
    input  logic          gray,
`endif
    output logic [AW-1:0] addr_r,
    input  logic [7:0]    rdata_r,
    output logic [AW-1:0] addr_g,
    input  logic [7:0]    rdata_g,
    output logic [AW-1:0] addr_b,
    input  logic [7:0]    rdata_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    y,
    output logic [7:0]    cb,
    output logic [7:0]    cr,
    output logic          out_last,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(PIX - 1);

    state_t          state, state_nxt;
    logic [AW-1:0]   rd_cnt;
    logic            stall, capture, cap_last, gray_q;
    logic [7:0]      r_p1, g_p1, b_p1;
    logic            vld_p1, last_p1;
    logic signed [17:0] rs, gs, bs, y_acc, cb_acc, cr_acc;
    logic [7:0]      y_c, cb_c, cr_c;

    function automatic logic signed [17:0] round_shift(input logic signed [17:0] acc);
        return (acc + 18'sd128) >>> 8;
    endfunction

    function automatic logic [7:0] clamp_u8(input logic signed [17:0] v);
        if (v < 0)
            return 8'd0;
        else if (v > 18'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    assign stall    = out_valid & ~out_ready;
    assign capture  = (state == RUN) & ~stall;
    assign cap_last = capture & (rd_cnt == LAST_ADDR);

    assign addr_r = rd_cnt;
    assign addr_g = rd_cnt;
    assign addr_b = rd_cnt;
    assign busy   = (state == RUN) || (state == DRAIN);
    assign done   = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cap_last) state_nxt = DRAIN;
            DRAIN:   if (out_valid & out_ready & out_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            rd_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start)
                rd_cnt <= '0;
            else if (capture && !cap_last)
                rd_cnt <= rd_cnt + 1'b1;
        end
    end

`ifdef YCBCR_GRAY_EN
    // Mode is latched at frame start so a toggling input cannot mix modes within a frame.
    always_ff @(posedge clk) begin
        if (reset)
            gray_q <= 1'b0;
        else if (state == IDLE && start)
            gray_q <= gray;
    end
`else
    assign gray_q = 1'b0;
`endif

    // S1: registered RGB from the asynchronous plane reads
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (capture) begin
            vld_p1  <= 1'b1;
            last_p1 <= cap_last;
        end else if (!stall) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            r_p1 <= rdata_r;
            g_p1 <= rdata_g;
            b_p1 <= rdata_b;
        end
    end

    always_comb begin
        rs     = $signed({10'd0, r_p1});
        gs     = $signed({10'd0, g_p1});
        bs     = $signed({10'd0, b_p1});
        y_acc  = 18'sd77 * rs + 18'sd150 * gs + 18'sd29 * bs;
        cb_acc = 18'sd128 * bs - 18'sd43 * rs - 18'sd85 * gs;
        cr_acc = 18'sd128 * rs - 18'sd107 * gs - 18'sd21 * bs;
        y_c    = clamp_u8(round_shift(y_acc));
        cb_c   = clamp_u8(round_shift(cb_acc) + 18'sd128);
        cr_c   = clamp_u8(round_shift(cr_acc) + 18'sd128);
    end

    // S2: output register, frozen while a presented beat is not accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            y         <= 8'd0;
            cb        <= 8'd0;
            cr        <= 8'd0;
        end else if (!stall) begin
            out_valid <= vld_p1;
            out_last  <= vld_p1 & last_p1;
            y         <= y_c;
            cb        <= gray_q ? 8'd128 : cb_c;
            cr        <= gray_q ? 8'd128 : cr_c;
        end
    end

endmodule

// File: tb/tb_ycbcr_stream_out.sv
// Scoreboard bench for ycbcr_stream_out: random planes, backpressure, mid-frame start and reset.
module tb_ycbcr_stream_out;

    localparam int PIX = 16384;
    localparam int AW  = 14;

    logic          clk = 1'b0;
    logic          reset, start, out_ready;
    logic [AW-1:0] addr_r, addr_g, addr_b;
    logic [7:0]    rdata_r, rdata_g, rdata_b;
    logic          out_valid, out_last, busy, done;
    logic [7:0]    y, cb, cr;
`ifdef YCBCR_GRAY_EN
    logic          gray;
`endif

    logic [7:0] mem_r [PIX];
    logic [7:0] mem_g [PIX];
    logic [7:0] mem_b [PIX];

    assign rdata_r = mem_r[addr_r];
    assign rdata_g = mem_g[addr_g];
    assign rdata_b = mem_b[addr_b];

    typedef struct packed {
        logic [7:0] py;
        logic [7:0] pcb;
        logic [7:0] pcr;
        logic       plast;
    } beat_t;

    beat_t exp_q[$];
    int    errors = 0;
    int    checks = 0;
    int    beats  = 0;
    int    mode   = 0;
    bit    pause_en   = 1'b0;
    bit    addr_watch = 1'b0;

    always #5 clk = ~clk;

    ycbcr_stream_out #(.PIX(PIX), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
`ifdef YCBCR_GRAY_EN
        .gray(gray),
`endif
        .addr_r(addr_r), .rdata_r(rdata_r),
        .addr_g(addr_g), .rdata_g(rdata_g),
        .addr_b(addr_b), .rdata_b(rdata_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .cb(cb), .cr(cr), .out_last(out_last),
        .busy(busy), .done(done)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int clamp255(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    // Reference conversion straight from the BT.601 formulas on plain integers.
    function automatic beat_t model(input int r, input int g, input int b, input bit last, input bit gr);
        beat_t bt;
        int yv, cbv, crv;
        yv  = (77 * r + 150 * g + 29 * b + 128) >>> 8;
        cbv = clamp255(((-43 * r - 85 * g + 128 * b + 128) >>> 8) + 128);
        crv = clamp255(((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128);
        if (gr) begin
            cbv = 128;
            crv = 128;
        end
        bt.py    = yv[7:0];
        bt.pcb   = cbv[7:0];
        bt.pcr   = crv[7:0];
        bt.plast = last;
        return bt;
    endfunction

    // kind: 0 random, 1 all 255, 2 random with three directed primaries first
    task automatic load(input int kind, input bit gr);
        int dr[3] = '{255, 0, 0};
        int dg[3] = '{0, 255, 0};
        int db[3] = '{0, 0, 255};
        int ey[3] = '{77, 149, 29};
        int ecb[3] = '{85, 43, 255};
        int ecr[3] = '{255, 21, 107};
        int r, g, b;
        beat_t bt;
        for (int i = 0; i < PIX; i++) begin
            r = (kind == 1) ? 255 : int'($urandom_range(0, 255));
            g = (kind == 1) ? 255 : int'($urandom_range(0, 255));
            b = (kind == 1) ? 255 : int'($urandom_range(0, 255));
            if (kind == 2 && i < 3) begin
                r = dr[i]; g = dg[i]; b = db[i];
                bt.py = ey[i][7:0]; bt.pcb = ecb[i][7:0]; bt.pcr = ecr[i][7:0];
                bt.plast = 1'b0;
            end else begin
                bt = model(r, g, b, i == PIX - 1, gr);
            end
            mem_r[i] = r[7:0];
            mem_g[i] = g[7:0];
            mem_b[i] = b[7:0];
            exp_q.push_back(bt);
        end
    endtask

    task automatic run_frame(input bit mid_start, input int limit, output int cyc, output int first_v);
        bit seen_done;
        seen_done = 1'b0;
        cyc = 0;
        first_v = -1;
        @(posedge clk); #1 start = 1'b1;
        while (!seen_done && cyc < limit) begin
            @(posedge clk);
            cyc++;
            #1 start = mid_start && (cyc == 200);
            if (mid_start && cyc == 200) check("busy_mid_frame", busy, 1);
            @(negedge clk);
            if (out_valid && first_v < 0) first_v = cyc;
            if (done) seen_done = 1'b1;
        end
        if (!seen_done) check("done_timeout", 0, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    // Monitor: compares every presented beat against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    check("beat", int'({y, cb, cr, out_last}), int'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        beats++;
                    end
                end
                if (addr_watch && !out_ready) begin
                    check("addr_r_frozen", int'(addr_r), 5002);
                    check("addr_g_frozen", int'(addr_g), 5002);
                    check("addr_b_frozen", int'(addr_b), 5002);
                end
            end
        end
    end

    // Ready driver: always-on, random 50%, or a one-shot 10-cycle pause at beat 5000.
    initial begin
        int pause_cnt;
        pause_cnt = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pause_en && beats == 5000 && pause_cnt < 10) begin
                out_ready = 1'b0;
                pause_cnt++;
            end
        end
    end

    initial begin
        int cyc, first_v, base, wait_cyc;
        bit gr_b, saw_done;
        reset = 1'b1;
        start = 1'b0;
`ifdef YCBCR_GRAY_EN
        gray = 1'b0;
        gr_b = 1'b1;
`else
        gr_b = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_yccc", int'({y, cb, cr}), 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", int'(addr_r), 0);

        // Frame A: directed primaries, 10-cycle pause at beat 5000, ignored mid-frame start
        load(2, 1'b0);
        pause_en = 1'b1;
        addr_watch = 1'b1;
        run_frame(1'b1, 20000, cyc, first_v);
        check("frameA_cycles", cyc, PIX + 3 + 10);
        check("frameA_beats", beats, PIX);
        pause_en = 1'b0;
        addr_watch = 1'b0;

        // Frame B: random data, random backpressure
        base = beats;
        mode = 1;
`ifdef YCBCR_GRAY_EN
        gray = gr_b;
`endif
        load(0, gr_b);
        run_frame(1'b0, 40000, cyc, first_v);
        check("frameB_beats", beats - base, PIX);
        mode = 0;
`ifdef YCBCR_GRAY_EN
        gray = 1'b0;
`endif

        // Frame C: abort with reset at beat 8000
        base = beats;
        load(0, 1'b0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_cyc = 0;
        while (beats - base < 8000 && wait_cyc < 20000) begin
            @(posedge clk);
            wait_cyc++;
        end
        check("frameC_reach_8000", beats - base, 8000);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_yccc", int'({y, cb, cr}), 0);
        check("abort_addr", int'(addr_r), 0);
        saw_done = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (done || out_valid) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 0);

        // Frame D: all 255 after the abort, full-rate timing
        base = beats;
        load(1, 1'b0);
        run_frame(1'b0, 20000, cyc, first_v);
        check("frameD_first_valid", first_v, 3);
        check("frameD_done_cycle", cyc, PIX + 3);
        check("frameD_beats", beats - base, PIX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
